cr_fifo_wrap3: RTL
==================

Name: cr_fifo_wrap3

Overview:
Parametrised successor of the 2-entry-flag FIFO wrapper. It is a single-clock FIFO with configurable width and depth, and supports any depth ≥2, not only powers of two. Almost-full/almost-empty thresholds are programmable at run time. It adds synchronous clear, sticky overflow/underflow status, and a selectable read mode (registered or first-word-fall-through). Sits between engine datapath stages wherever a buffered 1r1w queue with early back-pressure is needed.

Parameters:
DATA_WIDTH, 71, bits per entry
DEPTH, 2048, number of entries; legal range ≥2, need not be a power of two
CW, $clog2(DEPTH+1), width of slot counts and thresholds (derived; do not override)
FWFT, 0, 0 = registered read (data one cycle after ren); 1 = first-word-fall-through

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
clear  in  1  synchronous flush of contents
wen  in  1  write request
wdata  in  DATA_WIDTH  write data
ren  in  1  read request
rdata  out  DATA_WIDTH  read data
full  out  1  used_slots==DEPTH
empty  out  1  used_slots==0
afull  out  1  registered almost-full
aempty  out  1  registered almost-empty
afull_thresh  in  CW  assert afull when free_slots ≤ this value
aempty_thresh  in  CW  assert aempty when used_slots ≤ this value
used_slots  out  CW  occupied entries
free_slots  out  CW  DEPTH − used_slots
overflow  out  1  sticky: a write was attempted while full
underflow  out  1  sticky: a read was attempted while empty
err_clr  in  1  clears overflow and underflow

Behaviour:
- Reset (rst_n==0 at a clk edge): rd_ptr, wr_ptr and used all go to 0.
  - Output values under reset: empty=1, full=0, aempty=1, afull=0, overflow=0, underflow=0, rdata=0, used_slots=0, free_slots=DEPTH.
  - Memory contents are not reset.
- Accept rules:
  - wr_acc = wen & ~full.
  - rd_acc = ren & ~empty.
  - full and empty are decoded from the registered count, so they reflect the state before the current edge.
  - Write while full: dropped, even if a read is accepted in the same cycle.
  - Read while empty: rejected, even if a write is accepted in the same cycle.
- Count update: used_next = used + wr_acc − rd_acc. A simultaneous accepted read and write leaves the count unchanged.
- Pointers increment on accept and wrap from DEPTH−1 to 0. There is an explicit compare, not a bit truncation.
- Flags:
  - On each edge: afull ← (DEPTH − used_next) ≤ afull_thresh; aempty ← used_next ≤ aempty_thresh.
  - Both flags use look-ahead, so they are valid in the same cycle the count changes.
  - A threshold change takes effect at the next edge.
- Status:
  - overflow sets on wen & full; underflow sets on ren & empty.
  - err_clr clears both bits. When err_clr coincides with a new error event, set wins.
  - clear does not affect overflow or underflow.
- clear:
  - Has priority over wen and ren in the same cycle; neither is accepted and neither sets status.
  - Pointers and count go to 0.
  - afull/aempty are recomputed with used_next=0.
  - rdata goes to 0.
- FWFT=0:
  - On rd_acc, rdata ← mem[rd_ptr] at the edge, so data is valid in the cycle after the read.
  - Otherwise rdata holds its value.
- FWFT=1:
  - rdata = mem[rd_ptr] when ~empty, else 0. It is combinational from the registered pointer.
  - The head becomes visible the cycle after it is written into an empty FIFO.
  - ren pops the head and the next entry appears the following cycle.
- Storage: DEPTH×DATA_WIDTH register array. Write-first bypass is not provided.
- Illegal configurations:
  - Thresholds > DEPTH are legal: afull stays 1 when afull_thresh > DEPTH, and aempty stays 1 when aempty_thresh ≥ DEPTH.
  - DEPTH<2 is a compile-time error.

Test Plan:
- Reset and fill (DEPTH=8, DATA_WIDTH=8, FWFT=0, afull_thresh=2, aempty_thresh=1):
  - Hold rst_n=0 for 2 cycles → empty=1, aempty=1, afull=0, free_slots=8.
  - Write 0x10..0x17 → afull rises the edge used reaches 6; full after the 8th write; a 9th write sets overflow and leaves used=8.
- Drain (continues from the fill test):
  - Read 8 times → rdata sequence 0x10..0x17, each one cycle after its ren.
  - aempty rises when used reaches 1; a 9th ren sets underflow.
  - err_clr clears both status bits.
- Simultaneous read and write:
  - At used=8: wen&ren → read accepted, write dropped, overflow=1, used=7.
  - At used=0: wen&ren → write accepted, underflow=1, used=1.
  - At used=4: wen&ren → used stays 4 and the flags are unchanged.
- Wrap-around with non-power-of-two depth (DEPTH=5):
  - Stream 23 writes interleaved with reads, keeping occupancy between 1 and 4 → all data is returned in order across pointer wraps, and used_slots + free_slots = 5 every cycle.
- FWFT=1:
  - Write 0xAB into an empty FIFO → rdata=0xAB and empty=0 on the next cycle, with no ren.
  - ren pops 0xAB → rdata=0, empty=1.
- clear and late threshold change:
  - With used=6, assert clear together with wen → used=0, empty=1, aempty=1, the write is not stored, and the sticky bits are unchanged.
  - Change afull_thresh from 2 to 8 while empty → afull=1 on the next edge.

Source files
------------

// File: rtl/cr_fifo_wrap3_if.sv
// Handshake/status bundle for cr_fifo_wrap3. The producer/consumer side uses
// master and the FIFO uses slave.
interface cr_fifo_wrap3_if #(
  parameter int DATA_WIDTH = 71,
  parameter int DEPTH      = 2048,
  parameter int CW         = $clog2(DEPTH + 1)
);
  logic                  clear;
  logic                  wen;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ren;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  full;
  logic                  empty;
  logic                  afull;
  logic                  aempty;
  logic [CW-1:0]         afull_thresh;
  logic [CW-1:0]         aempty_thresh;
  logic [CW-1:0]         used_slots;
  logic [CW-1:0]         free_slots;
  logic                  overflow;
  logic                  underflow;
  logic                  err_clr;

  modport master (
    output clear, wen, wdata, ren, afull_thresh, aempty_thresh, err_clr,
    input  rdata, full, empty, afull, aempty, used_slots, free_slots,
           overflow, underflow
  );

  modport slave (
    input  clear, wen, wdata, ren, afull_thresh, aempty_thresh, err_clr,
    output rdata, full, empty, afull, aempty, used_slots, free_slots,
           overflow, underflow
  );
endinterface

// File: rtl/cr_fifo_wrap3.sv
// Single-clock 1r1w FIFO of arbitrary depth (>=2) with programmable almost
// flags, sticky overflow/underflow status and registered or FWFT read data.
module cr_fifo_wrap3 #(
  parameter int DATA_WIDTH = 71,
  parameter int DEPTH      = 2048,
  parameter int CW         = $clog2(DEPTH + 1),
  parameter bit FWFT       = 1'b0
) (
  input logic            clk,
  input logic            rst_n,
  cr_fifo_wrap3_if.slave bus
);
  localparam int             PW       = $clog2(DEPTH);
  localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0]  LAST_PTR = PW'(DEPTH - 1);

  if (DEPTH < 2) begin : g_depth_chk
    $error("cr_fifo_wrap3: DEPTH must be at least 2");
  end
  if (CW != $clog2(DEPTH + 1)) begin : g_cw_chk
    $error("cr_fifo_wrap3: CW is derived from DEPTH and must not be overridden");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr_reg;
  logic [PW-1:0]         wr_ptr_reg;
  logic [CW-1:0]         used_reg;
  logic [CW-1:0]         used_next;
  logic [CW-1:0]         free_next;
  logic                  afull_reg;
  logic                  aempty_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;
  logic                  full;
  logic                  empty;
  logic                  wr_acc;
  logic                  rd_acc;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign full   = (used_reg == DEPTH_C);
  assign empty  = (used_reg == '0);
  assign wr_acc = bus.wen & ~full  & ~bus.clear;
  assign rd_acc = bus.ren & ~empty & ~bus.clear;

  always_comb begin
    used_next = used_reg;
    if (bus.clear)
      used_next = '0;
    else if (wr_acc & ~rd_acc)
      used_next = used_reg + CW'(1);
    else if (rd_acc & ~wr_acc)
      used_next = used_reg - CW'(1);
    free_next = DEPTH_C - used_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      used_reg      <= '0;
      afull_reg     <= 1'b0;
      aempty_reg    <= 1'b1;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      used_reg   <= used_next;
      // Look-ahead on the next count so flags track the count edge-for-edge.
      afull_reg  <= (free_next <= bus.afull_thresh);
      aempty_reg <= (used_next <= bus.aempty_thresh);
      if (bus.clear) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
      end else begin
        if (wr_acc) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
        if (rd_acc) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      // A new error event beats err_clr; clear neither sets nor clears.
      overflow_reg  <= (overflow_reg  & ~bus.err_clr) | (bus.wen & full  & ~bus.clear);
      underflow_reg <= (underflow_reg & ~bus.err_clr) | (bus.ren & empty & ~bus.clear);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_reg] <= bus.wdata;
  end

  if (FWFT) begin : g_fwft
    assign bus.rdata = empty ? '0 : mem[rd_ptr_reg];
  end else begin : g_regread
    logic [DATA_WIDTH-1:0] rdata_reg;
    always_ff @(posedge clk) begin
      if (!rst_n || bus.clear)
        rdata_reg <= '0;
      else if (rd_acc)
        rdata_reg <= mem[rd_ptr_reg];
    end
    assign bus.rdata = rdata_reg;
  end

  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.afull      = afull_reg;
  assign bus.aempty     = aempty_reg;
  assign bus.used_slots = used_reg;
  assign bus.free_slots = DEPTH_C - used_reg;
  assign bus.overflow   = overflow_reg;
  assign bus.underflow  = underflow_reg;
endmodule
